// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer for the ID stage.
// It holds decode until the branch operands are ready, then evaluates the condition and
// issues a one-cycle PC redirect with an IF flush.
// Optional macro BRANCH_PREDICT_EN adds a 2-bit BHT. With the BHT, a redirect is issued
// only when the branch outcome differs from the prediction that decode carried.
module branch_resolve_ctrl #(
  parameter int unsigned MAX_WAIT  = 16,
  parameter int unsigned BHT_IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid_i,
  input  logic [5:0]  id_op_i,
  input  logic [31:0] id_pc_i,
  input  logic [15:0] id_offset_i,
  input  logic        rs_ready_i,
  input  logic        rt_ready_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
`ifdef BRANCH_PREDICT_EN
  input  logic [31:0] if_pc_i,
  output logic        if_pred_taken_o,
  input  logic        id_pred_taken_i,
`endif
  output logic        stall_id_o,
  output logic        flush_if_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        br_done_o,
  output logic        timeout_err_o
);

  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpBne  = 6'b000101;
  localparam logic [5:0] OpBgtz = 6'b000111;

  typedef enum logic [1:0] {StIdle, StWait, StResolve} state_e;

  state_e      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] offset_q, offset_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        taken_q, taken_d;
  logic        redir_q, redir_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        timeout_q, timeout_d;
  logic        pred_q, pred_d;

  logic        is_branch;
  logic        accept;
  logic        ready;
  logic        cond;
  logic        need_redir;
  logic [31:0] target;
  logic [31:0] fallthrough;

  // Decode the incoming opcode, check operand readiness and evaluate the latched branch.
  always_comb begin
    is_branch   = (id_op_i == OpBeq) || (id_op_i == OpBne) || (id_op_i == OpBgtz);
    // Gating with rst keeps stall_id low while reset is held.
    accept      = ~rst && (state_q == StIdle) && id_valid_i && is_branch;
    ready       = rs_ready_i && (rt_ready_i || (op_q == OpBgtz));
    target      = pc_q + 32'd4 + {{14{offset_q[15]}}, offset_q, 2'b00};
    fallthrough = pc_q + 32'd4;
    cond        = 1'b0;
    case (op_q)
      OpBeq:   cond = (rs_data_i == rt_data_i);
      OpBne:   cond = (rs_data_i != rt_data_i);
      OpBgtz:  cond = ($signed(rs_data_i) > 32'sd0);
      default: cond = 1'b0;
    endcase
`ifdef BRANCH_PREDICT_EN
    need_redir = (cond != pred_q);
`else
    need_redir = cond;
`endif
  end

  // Next-state and datapath capture for the IDLE -> WAIT -> RESOLVE sequence.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    pc_d          = pc_q;
    offset_d      = offset_q;
    wait_cnt_d    = wait_cnt_q;
    taken_d       = taken_q;
    redir_d       = redir_q;
    redirect_pc_d = redirect_pc_q;
    timeout_d     = 1'b0;
    pred_d        = pred_q;
    unique case (state_q)
      StIdle: begin
        wait_cnt_d = 8'd0;
        if (accept) begin
          op_d     = id_op_i;
          pc_d     = id_pc_i;
          offset_d = id_offset_i;
`ifdef BRANCH_PREDICT_EN
          pred_d   = id_pred_taken_i;
`endif
          state_d  = StWait;
        end
      end
      StWait: begin
        if (ready) begin
          taken_d       = cond;
          redir_d       = need_redir;
          redirect_pc_d = cond ? target : fallthrough;
          state_d       = StResolve;
        end else if (wait_cnt_q == 8'(MAX_WAIT - 1)) begin
          timeout_d  = 1'b1;
          wait_cnt_d = 8'd0;
          state_d    = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      StResolve: begin
        wait_cnt_d = 8'd0;
        state_d    = StIdle;
      end
      default: begin
        wait_cnt_d = 8'd0;
        state_d    = StIdle;
      end
    endcase
  end

  // State and captured-branch registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      op_q          <= 6'd0;
      pc_q          <= 32'd0;
      offset_q      <= 16'd0;
      wait_cnt_q    <= 8'd0;
      taken_q       <= 1'b0;
      redir_q       <= 1'b0;
      redirect_pc_q <= 32'd0;
      timeout_q     <= 1'b0;
      pred_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      pc_q          <= pc_d;
      offset_q      <= offset_d;
      wait_cnt_q    <= wait_cnt_d;
      taken_q       <= taken_d;
      redir_q       <= redir_d;
      redirect_pc_q <= redirect_pc_d;
      timeout_q     <= timeout_d;
      pred_q        <= pred_d;
    end
  end

  // Outputs decoded from registered state; only stall_id sees live inputs.
  always_comb begin
    stall_id_o       = accept || (state_q == StWait);
    br_done_o        = (state_q == StResolve);
    redirect_valid_o = br_done_o && redir_q;
    flush_if_o       = redirect_valid_o;
    redirect_pc_o    = redirect_valid_o ? redirect_pc_q : 32'd0;
    timeout_err_o    = timeout_q;
  end

`ifdef BRANCH_PREDICT_EN
  logic [1:0] bht_q [2**BHT_IDX_W];
  logic       unused_if_pc;

  assign unused_if_pc = ^{if_pc_i[31:BHT_IDX_W+2], if_pc_i[1:0], pc_q[31:BHT_IDX_W+2],
                          pc_q[1:0]};

  // Combinational fetch-side read; an update in the same cycle is seen from the next cycle.
  always_comb begin
    if_pred_taken_o = bht_q[if_pc_i[BHT_IDX_W+1:2]][1];
  end

  // Saturating counter update for the resolved branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**BHT_IDX_W; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (state_q == StResolve) begin
      if (taken_q) begin
        if (bht_q[pc_q[BHT_IDX_W+1:2]] != 2'b11) begin
          bht_q[pc_q[BHT_IDX_W+1:2]] <= bht_q[pc_q[BHT_IDX_W+1:2]] + 2'b01;
        end
      end else begin
        if (bht_q[pc_q[BHT_IDX_W+1:2]] != 2'b00) begin
          bht_q[pc_q[BHT_IDX_W+1:2]] <= bht_q[pc_q[BHT_IDX_W+1:2]] - 2'b01;
        end
      end
    end
  end
`else
  logic unused_cfg;
  logic unused_taken;

  assign unused_cfg   = ^BHT_IDX_W;
  assign unused_taken = taken_q ^ pred_q;
`endif

endmodule
